// File: rtl/pc_unit.sv
// Program counter with sequential advance, redirect, stall and an optional
// circular return-address stack (enabled by defining PC_RAS_EN).
module pc_unit #(
    parameter int               WIDTH     = 32,
    parameter int               INC       = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int               RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             load,
    input  logic [WIDTH-1:0] in_data,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] out_data,
    output logic [4:0]       ras_count,
    output logic             ras_ovf,
    output logic             ras_unf
);

    localparam logic [WIDTH-1:0] INC_V = WIDTH'(INC);

    logic [WIDTH-1:0] pc_seq;
    logic [WIDTH-1:0] pc_next;

    assign pc_seq = out_data + INC_V;

`ifdef PC_RAS_EN
    localparam int              PTR_W   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(RAS_DEPTH - 1);
    localparam logic [4:0]      CNT_MAX = 5'(RAS_DEPTH);

    if (RAS_DEPTH < 2 || RAS_DEPTH > 16) begin : g_depth_check
        $error("pc_unit: RAS_DEPTH must be in 2..16");
    end

    logic [WIDTH-1:0] stack_mem [RAS_DEPTH];
    logic [PTR_W-1:0] top_ptr;
    logic [PTR_W-1:0] top_inc;
    logic [PTR_W-1:0] top_dec;
    logic [PTR_W-1:0] top_next;
    logic [4:0]       count_next;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;
    logic             do_swap;
    logic             do_unf;
    logic             do_ovf;

    // top_ptr always names the newest entry; a push onto a full stack lands
    // on the oldest slot, which is exactly the overwrite we want.
    always_comb begin
        top_inc    = (top_ptr == PTR_MAX) ? '0 : top_ptr + 1'b1;
        top_dec    = (top_ptr == '0) ? PTR_MAX : top_ptr - 1'b1;
        empty      = (ras_count == 5'd0);
        full       = (ras_count == CNT_MAX);
        do_unf     = !stall && ret && empty;
        do_swap    = !stall && ret && !empty && load && call;
        do_pop     = !stall && ret && !empty && !(load && call);
        do_push    = !stall && !ret && load && call;
        do_ovf     = do_push && full;
        top_next   = top_ptr;
        count_next = ras_count;
        if (do_push) begin
            top_next = top_inc;
            if (!full) count_next = ras_count + 5'd1;
        end else if (do_pop) begin
            top_next   = top_dec;
            count_next = ras_count - 5'd1;
        end
    end

    always_comb begin
        pc_next = out_data;
        if (stall)              pc_next = out_data;
        else if (ret && !empty) pc_next = stack_mem[top_ptr];
        else if (ret)           pc_next = pc_seq;
        else if (load)          pc_next = in_data;
        else                    pc_next = pc_seq;
    end

    // Entry storage carries no reset; entries are only read when ras_count > 0.
    always_ff @(posedge clk) begin
        if (do_push)      stack_mem[top_inc] <= pc_seq;
        else if (do_swap) stack_mem[top_ptr] <= pc_seq;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            top_ptr   <= '0;
            ras_count <= 5'd0;
            ras_ovf   <= 1'b0;
            ras_unf   <= 1'b0;
        end else begin
            top_ptr   <= top_next;
            ras_count <= count_next;
            ras_ovf   <= do_ovf;
            ras_unf   <= do_unf;
        end
    end
`else
    logic unused_ras;

    assign unused_ras = call | ret | (RAS_DEPTH == 0);
    assign ras_count  = 5'd0;
    assign ras_ovf    = 1'b0;
    assign ras_unf    = 1'b0;

    always_comb begin
        pc_next = out_data;
        if (stall)     pc_next = out_data;
        else if (load) pc_next = in_data;
        else           pc_next = pc_seq;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) out_data <= RESET_VEC;
        else       out_data <= pc_next;
    end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit; the reference model follows PC_RAS_EN.
module tb_pc_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        load;
    logic [31:0] in_data;
    logic        call;
    logic        ret;
    logic [31:0] out_data;
    logic [4:0]  ras_count;
    logic        ras_ovf;
    logic        ras_unf;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  cnt;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_pc;
    logic [31:0] m_stack[$];
    int          n_checks;
    int          n_fail;

    pc_unit #(
        .WIDTH(32), .INC(4), .RESET_VEC(32'h0), .RAS_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .load(load), .in_data(in_data),
        .call(call), .ret(ret), .out_data(out_data), .ras_count(ras_count),
        .ras_ovf(ras_ovf), .ras_unf(ras_unf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: advance one clock edge with the given inputs.
    task automatic model_step(input logic s, input logic l, input logic c, input logic r,
                              input logic [31:0] d, output exp_t e);
        logic [31:0] tmp;
        e.ovf = 1'b0;
        e.unf = 1'b0;
`ifdef PC_RAS_EN
        if (s) begin
        end else if (r && m_stack.size() > 0) begin
            if (l && c) begin
                tmp = m_stack[$];
                m_stack[m_stack.size()-1] = m_pc + 32'd4;
                m_pc = tmp;
            end else begin
                m_pc = m_stack.pop_back();
            end
        end else if (r) begin
            e.unf = 1'b1;
            m_pc  = m_pc + 32'd4;
        end else if (l) begin
            if (c) begin
                m_stack.push_back(m_pc + 32'd4);
                if (m_stack.size() > 4) begin
                    void'(m_stack.pop_front());
                    e.ovf = 1'b1;
                end
            end
            m_pc = d;
        end else begin
            m_pc = m_pc + 32'd4;
        end
        e.cnt = 5'(m_stack.size());
`else
        if (!s) m_pc = l ? d : m_pc + 32'd4;
        e.cnt = 5'd0;
`endif
        e.pc = m_pc;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input string tag, input logic s, input logic l, input logic c,
                        input logic r, input logic [31:0] d);
        exp_t e;
        exp_t got;
        stall = s; load = l; call = c; ret = r; in_data = d;
        model_step(s, l, c, r, d, e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_val({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            got = sb.pop_front();
            check_val({tag, "_pc"}, out_data, got.pc);
            check_val({tag, "_cnt"}, {27'd0, ras_count}, {27'd0, got.cnt});
            check_val({tag, "_ovf"}, {31'd0, ras_ovf}, {31'd0, got.ovf});
            check_val({tag, "_unf"}, {31'd0, ras_unf}, {31'd0, got.unf});
        end
        @(negedge clk);
    endtask

    // Asserts reset between edges with junk controls pending, checks the
    // immediate effect, then releases at the following falling edge.
    task automatic do_reset(input string tag);
        #2;
        stall = 1'b1; load = 1'b1; call = 1'b1; ret = 1'b1; in_data = 32'h77;
        reset = 1'b1;
        #1;
        check_val({tag, "_pc"}, out_data, 32'h0);
        check_val({tag, "_cnt"}, {27'd0, ras_count}, 32'd0);
        check_val({tag, "_pulses"}, {30'd0, ras_ovf, ras_unf}, 32'd0);
        m_pc = 32'h0;
        m_stack.delete();
        @(negedge clk);
        stall = 1'b0; load = 1'b0; call = 1'b0; ret = 1'b0; in_data = 32'h0;
        reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1; stall = 1'b0; load = 1'b0; call = 1'b0; ret = 1'b0; in_data = '0;
        m_pc = 32'h0;
        #1;
        check_val("por_pc", out_data, 32'h0);
        check_val("por_cnt", {27'd0, ras_count}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Free running after reset: 4, 8, 12
        step("free1", 0, 0, 0, 0, 0);
        step("free2", 0, 0, 0, 0, 0);
        step("free3", 0, 0, 0, 0, 0);
        check_val("free_seq12", out_data, 32'd12);

        // Redirect and stall from PC 8
        do_reset("rst_a");
        step("adv1", 0, 0, 0, 0, 0);
        step("adv2", 0, 0, 0, 0, 0);
        step("load30", 0, 1, 0, 0, 32'd30);
        check_val("load30_abs", out_data, 32'd30);
        step("stall40", 1, 1, 0, 0, 32'd40);
        check_val("stall_hold", out_data, 32'd30);
        step("load40", 0, 1, 0, 0, 32'd40);
        check_val("load40_abs", out_data, 32'd40);

        // Call / return / underflow from PC 0x20
        do_reset("rst_b");
        step("to20", 0, 1, 0, 0, 32'h20);
        step("call100", 0, 1, 1, 0, 32'h100);
        step("ret1", 0, 0, 0, 1, 32'h0);
        step("ret_unf", 0, 0, 0, 1, 32'h0);
        step("after_unf", 0, 0, 0, 0, 32'h0);
        step("call_noload", 0, 0, 1, 0, 32'h900);
`ifdef PC_RAS_EN
        check_val("call_noload_cnt", {27'd0, ras_count}, 32'd0);
`endif

        // Overflow: five calls from PC 0, then drain and underflow
        do_reset("rst_c");
        for (int i = 1; i <= 5; i++) step("ovf_call", 0, 1, 1, 0, 32'(i) << 8);
        for (int i = 0; i < 5; i++) step("ovf_ret", 0, 0, 0, 1, 32'h0);

        // Coroutine swap, stalled ret, ret beating load
        do_reset("rst_d");
        step("sw_call", 0, 1, 1, 0, 32'h100);
        step("sw_swap", 0, 1, 1, 1, 32'h500);
        step("sw_stall", 1, 0, 0, 1, 32'h0);
        step("sw_retld", 0, 1, 0, 1, 32'h700);
        step("sw_swap_empty", 0, 1, 1, 1, 32'h800);

        // Wrap, then async reset mid-operation with a full stack
        step("to_top", 0, 1, 0, 0, 32'hFFFF_FFFC);
        step("wrap", 0, 0, 0, 0, 32'h0);
        check_val("wrap_abs", out_data, 32'h0);
        for (int i = 0; i < 4; i++) step("fill", 0, 1, 1, 0, 32'h40 * 32'(i + 1));
        do_reset("rst_mid");
        step("post_rst", 0, 0, 0, 1, 32'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom % 8) == 0, ($urandom % 3) == 0, ($urandom % 2) == 0,
                 ($urandom % 4) == 0, $urandom & 32'hFFFF_FFFC);
        end

        check_val("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
